// File: rtl/uart_program_loader_pkg.sv
// Shared types and defaults for the UART program loader and its receiver core.
// Build option UART_RX_SYNC_EN (see uart_rx_core) does not affect this package.
package uart_program_loader_pkg;

    localparam int CLK_FREQ_HZ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT        = 9600;
    localparam int DATA_W              = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        CLEANUP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N-style serial receiver without stop-bit check; one-cycle valid per received byte.
// Build option: define UART_RX_SYNC_EN to put a two-flop synchronizer ahead of the input register.
module uart_rx_core
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int BAUD        = BAUD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_rx,
    output logic              io_data_valid,
    output logic [DATA_W-1:0] io_data_packet
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    logic              rx_in;
    logic              rx_p0;
    rx_state_t         state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        bit_idx, bit_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic [DATA_W-1:0] packet_next;
    logic              valid_next;

`ifdef UART_RX_SYNC_EN
    logic rx_meta, rx_sync;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= io_rx;
            rx_sync <= rx_meta;
        end
    end
    assign rx_in = rx_sync;
`else
    assign rx_in = io_rx;
`endif

    // Stage p0: registered line, seen idle-high out of reset.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) rx_p0 <= 1'b1;
        else         rx_p0 <= rx_in;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            io_data_packet <= '0;
            io_data_valid  <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            bit_idx        <= bit_next;
            shift          <= shift_next;
            io_data_packet <= packet_next;
            io_data_valid  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        bit_next    = bit_idx;
        shift_next  = shift;
        packet_next = io_data_packet;
        valid_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rx_p0) state_next = START;
            end
            START: begin
                // A low that is gone by mid start bit is treated as a glitch.
                if (cnt == CNT_W'(HALF_BIT - 1)) begin
                    cnt_next   = '0;
                    state_next = rx_p0 ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    shift_next = {rx_p0, shift[DATA_W-1:1]};
                    if (bit_idx == 3'd7) begin
                        packet_next = {rx_p0, shift[DATA_W-1:1]};
                        valid_next  = 1'b1;
                        state_next  = CLEANUP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            CLEANUP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a byte stream over UART and emits little-endian halfwords with running byte addresses.
// Build option: define UART_RX_SYNC_EN to synchronize io_rx through two extra flops.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int BAUD        = BAUD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              io_rx,
    output logic              io_data_valid,
    output logic [DATA_W-1:0] io_data_packet,
    output logic [15:0]       instruction_word,
    output logic [31:0]       byte_address,
    output logic              word_valid
);
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic              high_phase;
    logic [DATA_W-1:0] low_byte;
    logic [31:0]       next_addr;

    uart_rx_core #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) u_rx (
        .clk            (clk),
        .reset_n        (reset_n),
        .io_rx          (io_rx),
        .io_data_valid  (vld_p0),
        .io_data_packet (data_p0)
    );

    assign io_data_valid  = vld_p0;
    assign io_data_packet = data_p0;

    // Stage p1: the second byte of each pair completes a halfword one cycle after its valid.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            high_phase       <= 1'b0;
            low_byte         <= '0;
            instruction_word <= '0;
            byte_address     <= '0;
            next_addr        <= '0;
            word_valid       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (vld_p0) begin
                if (!high_phase) begin
                    low_byte   <= data_p0;
                    high_phase <= 1'b1;
                end else begin
                    high_phase       <= 1'b0;
                    instruction_word <= {data_p0, low_byte};
                    byte_address     <= next_addr;
                    next_addr        <= next_addr + 32'd2;
                    word_valid       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: table burst, directed corner cases, random stream.
module tb_uart_program_loader;
    localparam int CLK_FREQ_HZ = 6400;
    localparam int BAUD        = 100;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;
    localparam int HALF        = CPB / 2;
    localparam int START_LEN   = CPB + HALF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        io_rx = 1'b1;
    logic        io_data_valid;
    logic [7:0]  io_data_packet;
    logic [15:0] instruction_word;
    logic [31:0] byte_address;
    logic        word_valid;

    uart_program_loader #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .io_rx            (io_rx),
        .io_data_valid    (io_data_valid),
        .io_data_packet   (io_data_packet),
        .instruction_word (instruction_word),
        .byte_address     (byte_address),
        .word_valid       (word_valid)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;

    logic [7:0]  got_bytes[$];
    longint      got_byte_cyc[$];
    logic [15:0] got_words[$];
    logic [31:0] got_addrs[$];
    longint      got_word_cyc[$];
    logic [7:0]  exp_bytes[$];

    typedef struct {
        logic [7:0]  data;
        logic        word_exp;
        logic [15:0] word;
        logic [31:0] addr;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] instr[12];
    int          wi;
    int          nb;
    logic [7:0]  b;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_data_valid) begin
            got_bytes.push_back(io_data_packet);
            got_byte_cyc.push_back(cyc);
        end
        if (word_valid) begin
            got_words.push_back(instruction_word);
            got_addrs.push_back(byte_address);
            got_word_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_capture();
        got_bytes.delete();
        got_byte_cyc.delete();
        got_words.delete();
        got_addrs.delete();
        got_word_cyc.delete();
        exp_bytes.delete();
    endtask

    // Each line level is held for n clocks; changes land 1 ns after a rising edge.
    task automatic drive(input logic v, input int n);
        io_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit of 1.5 bit periods, eight data bits LSB first, no stop bit.
    task automatic send_frame(input logic [7:0] d);
        drive(1'b0, START_LEN);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
    endtask

    task automatic do_reset();
        reset_n = 1'b1;
        io_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_capture();
        reset_n = 1'b0;
        drive(1'b1, 4);
    endtask

    // Expected stream from byte list: halfword j = {byte[2j+1], byte[2j]} at address 2j.
    task automatic compare_stream(input string tag);
        int nw;
        nw = exp_bytes.size() / 2;
        check({tag, "_nbytes"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            if (i < got_bytes.size())
                check($sformatf("%s_byte%0d", tag, i), {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        check({tag, "_nwords"}, got_words.size(), nw);
        for (int j = 0; j < nw; j++) begin
            if (j < got_words.size()) begin
                check($sformatf("%s_word%0d", tag, j), {16'd0, got_words[j]},
                      {16'd0, exp_bytes[2*j+1], exp_bytes[2*j]});
                check($sformatf("%s_addr%0d", tag, j), got_addrs[j], 32'(2 * j));
            end
        end
    endtask

    initial begin
        tbl[0] = '{8'h93, 1'b0, 16'h0000, 32'd0};
        tbl[1] = '{8'h00, 1'b1, 16'h0093, 32'd0};
        tbl[2] = '{8'hA0, 1'b0, 16'h0000, 32'd0};
        tbl[3] = '{8'h00, 1'b1, 16'h00A0, 32'd2};
        tbl[4] = '{8'h00, 1'b0, 16'h0000, 32'd0};
        tbl[5] = '{8'hE7, 1'b1, 16'hE700, 32'd4};
        tbl[6] = '{8'hFF, 1'b0, 16'h0000, 32'd0};
        tbl[7] = '{8'h5A, 1'b1, 16'h5AFF, 32'd6};

        // Reset state
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_valid", {31'd0, io_data_valid}, 32'd0);
        check("rst_packet", {24'd0, io_data_packet}, 32'd0);
        check("rst_word", {16'd0, instruction_word}, 32'd0);
        check("rst_addr", byte_address, 32'd0);
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        reset_n = 1'b0;
        drive(1'b1, 2 * CPB);

        // Single byte with idle line afterwards
        send_frame(8'h93);
        drive(1'b1, 3 * CPB);
        check("single_nbytes", got_bytes.size(), 1);
        if (got_bytes.size() > 0) check("single_byte", {24'd0, got_bytes[0]}, 32'h93);
        check("single_nwords", got_words.size(), 0);
        check("single_hold", {24'd0, io_data_packet}, 32'h93);

        // Table burst, back-to-back without stop bits
        do_reset();
        for (int i = 0; i < 8; i++) send_frame(tbl[i].data);
        drive(1'b1, 3 * CPB);
        check("tbl_nbytes", got_bytes.size(), 8);
        check("tbl_nwords", got_words.size(), 4);
        wi = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < got_bytes.size())
                check($sformatf("tbl_byte%0d", i), {24'd0, got_bytes[i]}, {24'd0, tbl[i].data});
            if (tbl[i].word_exp) begin
                if (wi < got_words.size() && i < got_bytes.size()) begin
                    check($sformatf("tbl_word%0d", wi), {16'd0, got_words[wi]}, {16'd0, tbl[i].word});
                    check($sformatf("tbl_addr%0d", wi), got_addrs[wi], tbl[i].addr);
                    check($sformatf("tbl_lat%0d", wi), 32'(got_word_cyc[wi] - got_byte_cyc[i]), 32'd1);
                end
                wi++;
            end
        end
        check("tbl_hold_word", {16'd0, instruction_word}, 32'h5AFF);
        check("tbl_hold_addr", byte_address, 32'd6);

        // 48-byte program image, one unbroken burst
        do_reset();
        instr[0] = 32'h00A00093;
        for (int i = 1; i < 11; i++) instr[i] = $urandom;
        instr[11] = 32'h401505B3;
        for (int i = 0; i < 12; i++)
            for (int k = 0; k < 4; k++) begin
                b = instr[i][8*k +: 8];
                exp_bytes.push_back(b);
                send_frame(b);
            end
        drive(1'b1, 3 * CPB);
        compare_stream("prog");
        check("prog_nwords24", got_words.size(), 24);
        if (got_words.size() >= 24) begin
            check("prog_last_word", {16'd0, got_words[23]}, 32'h4015);
            check("prog_last_addr", got_addrs[23], 32'd46);
        end

        // Short low glitch while idle is rejected, then a real byte still arrives
        do_reset();
        drive(1'b0, HALF - 12);
        drive(1'b1, 12 * CPB);
        check("glitch_nbytes", got_bytes.size(), 0);
        send_frame(8'h5A);
        drive(1'b1, 3 * CPB);
        check("glitch_after_nbytes", got_bytes.size(), 1);
        if (got_bytes.size() > 0) check("glitch_after_byte", {24'd0, got_bytes[0]}, 32'h5A);

        // Reset during bit 4 of the second byte discards the pending half
        do_reset();
        send_frame(8'hC3);
        drive(1'b0, START_LEN);
        for (int i = 0; i < 4; i++) drive(b[i], CPB);
        drive(1'b1, HALF);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_packet", {24'd0, io_data_packet}, 32'd0);
        check("midrst_word", {16'd0, instruction_word}, 32'd0);
        clear_capture();
        reset_n = 1'b0;
        drive(1'b1, 2 * CPB);
        exp_bytes.push_back(8'h13);
        exp_bytes.push_back(8'h00);
        send_frame(8'h13);
        send_frame(8'h00);
        drive(1'b1, 3 * CPB);
        compare_stream("midrst");
        if (got_words.size() > 0) begin
            check("midrst_first_word", {16'd0, got_words[0]}, 32'h0013);
            check("midrst_first_addr", got_addrs[0], 32'd0);
        end

        // Random bursts separated by idle gaps of random length
        do_reset();
        for (int k = 0; k < 5; k++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                exp_bytes.push_back(b);
                send_frame(b);
            end
            drive(1'b1, CPB + $urandom_range(8, CPB));
        end
        drive(1'b1, 2 * CPB);
        compare_stream("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
